csr_access_arbiter: RTL and testbench
=====================================

CSR_ACCESS_ARBITER -- requirements
Module: csr_access_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, CSR address width.
REQ-002 Parameter DATA_W, default 64, CSR data width.
REQ-003 Parameter CMD_W, default 3, CSR command width; command 0 = no-op.
REQ-004 clk_i  in  1  clock; all state on posedge.
REQ-005 reset_l  in  1  reset; asynchronous, active-low.
REQ-006 core_req_valid_i / core_req_ready_o  in/out  1  core request handshake (port 0).
REQ-007 core_req_addr_i, core_req_cmd_i, core_req_wdata_i  in  ADDR_W/CMD_W/DATA_W  core request payload.
REQ-008 dbg_req_valid_i / dbg_req_ready_o  in/out  1  debug request handshake (port 1).
REQ-009 dbg_req_addr_i, dbg_req_cmd_i, dbg_req_wdata_i  in  ADDR_W/CMD_W/DATA_W  debug request payload.
REQ-010 rsp_valid_o  out  1  response valid.
REQ-011 rsp_ready_i  in  1  response accepted by its owner.
REQ-012 rsp_port_o  out  1  response owner (0 = core, 1 = debug).
REQ-013 rsp_rdata_o  out  DATA_W  captured read data.
REQ-014 rsp_err_o  out  1  captured exception flag.
REQ-015 csr_addr_o, csr_cmd_o, csr_wdata_o  out  ADDR_W/CMD_W/DATA_W  drive to the shared CSR regfile.
REQ-016 csr_rdata_i, csr_exception_i  in  DATA_W/1  combinational regfile result for the current command.
REQ-017 access_cnt_o  out  16  saturating count of completed accesses.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-019 In IDLE, a grant is combinational: one valid requester wins; with both valid, the port not granted last wins.
REQ-020 The last-grant pointer SHALL update only on an accepted request.
REQ-021 x_req_ready_o SHALL be high only in IDLE for the granted port, and at most one ready is high per cycle.
REQ-022 In an accept cycle (valid & ready, cycle T), the block latches the payload and port and moves to ACCESS at T+1.
REQ-023 In ACCESS, the block drives csr_addr_o, csr_cmd_o and csr_wdata_o from the latched payload for exactly one cycle.
REQ-024 In ACCESS, the block captures csr_rdata_i and csr_exception_i into the response registers and moves to RESP.
REQ-025 Outside ACCESS, csr_cmd_o SHALL be 0, and csr_addr_o and csr_wdata_o SHALL be 0.
REQ-026 In RESP (from T+2), rsp_valid_o is high; rsp_port_o, rsp_rdata_o and rsp_err_o stay stable until rsp_ready_i.
REQ-027 RESP SHALL exit to IDLE on the cycle after rsp_valid_o & rsp_ready_i, so the minimum period is 3 cycles per access.
REQ-028 Request valid/payload changes while ready is low SHALL be ignored, with no buffering beyond one in-flight access.
REQ-029 A command-0 request SHALL be accepted and sequenced normally, return rsp_err_o=0, and drive csr_cmd_o=0 in ACCESS.
REQ-030 access_cnt_o SHALL increment on each response handshake and saturate at 16'hFFFF without wrapping.
REQ-031 rsp_valid_o SHALL never be asserted in IDLE or ACCESS.

Reset
REQ-032 While reset_l=0, the block SHALL be in state IDLE.
REQ-033 While reset_l=0, both readies, rsp_valid_o, rsp_port_o, rsp_rdata_o, rsp_err_o, all csr_*_o outputs and access_cnt_o SHALL be 0.
REQ-034 While reset_l=0, the last-grant pointer SHALL be 1, so the core wins the first tie.
REQ-035 Reset asserted in ACCESS or RESP SHALL abort the access immediately with no response, and the block resumes in IDLE.

Verification
REQ-036 Single core read: core valid at T with addr 12'h300, cmd 5, csr_rdata_i=64'hA5 -> core_req_ready_o=1 at T; csr_cmd_o=5 and csr_addr_o=12'h300 only at T+1; rsp_valid_o=1 at T+2 with rsp_port_o=0 and rsp_rdata_o=64'hA5.
REQ-037 Tie after reset: both valid continuously, rsp_ready_i=1 -> grants alternate core, debug, core, debug, one every 3 cycles; access_cnt_o=4 after the 4th handshake.
REQ-038 Backpressure: rsp_ready_i=0 for 10 cycles while csr_rdata_i changes -> rsp_valid_o held, rsp_rdata_o stable, both readies 0, no new csr_cmd_o.
REQ-039 Exception: csr_exception_i=1 during ACCESS for a debug write -> rsp_err_o=1 with rsp_port_o=1 at T+2.
REQ-040 Saturation: preset 65535 handshakes (or force the counter to 16'hFFFE), then 3 more -> access_cnt_o reads 16'hFFFF and stays there.
REQ-041 Reset in RESP: reset_l=0 while rsp_valid_o=1 -> all outputs 0 asynchronously; after release, a core request is served with normal T/T+1/T+2 timing.

Source files
------------

// File: rtl/csr_access_arbiter.sv
// Two-port (core/debug) arbiter in front of a shared combinational CSR regfile.
// One access in flight: IDLE grant -> ACCESS drive/capture -> RESP hold until accepted.
module csr_access_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int CMD_W  = 3
) (
    input  logic              clk_i,
    input  logic              reset_l,
    input  logic              core_req_valid_i,
    output logic              core_req_ready_o,
    input  logic [ADDR_W-1:0] core_req_addr_i,
    input  logic [CMD_W-1:0]  core_req_cmd_i,
    input  logic [DATA_W-1:0] core_req_wdata_i,
    input  logic              dbg_req_valid_i,
    output logic              dbg_req_ready_o,
    input  logic [ADDR_W-1:0] dbg_req_addr_i,
    input  logic [CMD_W-1:0]  dbg_req_cmd_i,
    input  logic [DATA_W-1:0] dbg_req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_port_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic [CMD_W-1:0]  csr_cmd_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    input  logic              csr_exception_i,
    output logic [15:0]       access_cnt_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_reg, state_next;
    logic                last_grant_reg;
    logic                req_port_reg;
    logic [ADDR_W-1:0]   req_addr_reg;
    logic [CMD_W-1:0]    req_cmd_reg;
    logic [DATA_W-1:0]   req_wdata_reg;
    logic                rsp_port_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                rsp_err_reg;
    logic [15:0]         cnt_reg;

    logic grant_valid;
    logic grant_port;
    logic accept;
    logic rsp_hs;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant_valid = core_req_valid_i | dbg_req_valid_i;
        if (core_req_valid_i && dbg_req_valid_i)
            grant_port = ~last_grant_reg;
        else
            grant_port = dbg_req_valid_i;
    end

    // Readies are gated by reset so nothing looks accepted while held in reset.
    assign accept           = reset_l & (state_reg == IDLE) & grant_valid;
    assign core_req_ready_o = accept & ~grant_port;
    assign dbg_req_ready_o  = accept & grant_port;
    assign rsp_hs           = (state_reg == RESP) & rsp_ready_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            req_port_reg   <= 1'b0;
            req_addr_reg   <= '0;
            req_cmd_reg    <= '0;
            req_wdata_reg  <= '0;
            rsp_port_reg   <= 1'b0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                last_grant_reg <= grant_port;
                req_port_reg   <= grant_port;
                req_addr_reg   <= grant_port ? dbg_req_addr_i  : core_req_addr_i;
                req_cmd_reg    <= grant_port ? dbg_req_cmd_i   : core_req_cmd_i;
                req_wdata_reg  <= grant_port ? dbg_req_wdata_i : core_req_wdata_i;
            end
            // A no-op command never reports an exception.
            if (state_reg == ACCESS) begin
                rsp_port_reg  <= req_port_reg;
                rsp_rdata_reg <= csr_rdata_i;
                rsp_err_reg   <= csr_exception_i & (req_cmd_reg != '0);
            end
            if (rsp_hs && cnt_reg != 16'hFFFF)
                cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign csr_addr_o   = (state_reg == ACCESS) ? req_addr_reg  : '0;
    assign csr_cmd_o    = (state_reg == ACCESS) ? req_cmd_reg   : '0;
    assign csr_wdata_o  = (state_reg == ACCESS) ? req_wdata_reg : '0;
    assign rsp_valid_o  = (state_reg == RESP);
    assign rsp_port_o   = rsp_port_reg;
    assign rsp_rdata_o  = rsp_rdata_reg;
    assign rsp_err_o    = rsp_err_reg;
    assign access_cnt_o = cnt_reg;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter: timing, arbitration, backpressure,
// exception, no-op, counter saturation and reset-in-RESP.
module tb_csr_access_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_l;
    logic        core_req_valid_i, dbg_req_valid_i;
    logic        core_req_ready_o, dbg_req_ready_o;
    logic [11:0] core_req_addr_i, dbg_req_addr_i;
    logic [2:0]  core_req_cmd_i, dbg_req_cmd_i;
    logic [63:0] core_req_wdata_i, dbg_req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_port_o, rsp_err_o;
    logic [63:0] rsp_rdata_o;
    logic [11:0] csr_addr_o;
    logic [2:0]  csr_cmd_o;
    logic [63:0] csr_wdata_o, csr_rdata_i;
    logic        csr_exception_i;
    logic [15:0] access_cnt_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = 16'd0;

    always #5 clk_i = ~clk_i;

    csr_access_arbiter dut (
        .clk_i(clk_i), .reset_l(reset_l),
        .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
        .core_req_addr_i(core_req_addr_i), .core_req_cmd_i(core_req_cmd_i),
        .core_req_wdata_i(core_req_wdata_i),
        .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
        .dbg_req_addr_i(dbg_req_addr_i), .dbg_req_cmd_i(dbg_req_cmd_i),
        .dbg_req_wdata_i(dbg_req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_port_o(rsp_port_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .csr_addr_o(csr_addr_o), .csr_cmd_o(csr_cmd_o), .csr_wdata_o(csr_wdata_o),
        .csr_rdata_i(csr_rdata_i), .csr_exception_i(csr_exception_i),
        .access_cnt_o(access_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bump_cnt();
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    // One request from cycle T through the response handshake, checking T/T+1/T+2.
    task automatic access(input logic port, input logic [11:0] addr, input logic [2:0] cmd,
                          input logic [63:0] wd, input logic [63:0] rd,
                          input logic exc, input logic exp_err);
        @(negedge clk_i);
        if (port) begin
            dbg_req_valid_i = 1'b1; dbg_req_addr_i = addr;
            dbg_req_cmd_i = cmd; dbg_req_wdata_i = wd;
        end else begin
            core_req_valid_i = 1'b1; core_req_addr_i = addr;
            core_req_cmd_i = cmd; core_req_wdata_i = wd;
        end
        csr_rdata_i = rd; csr_exception_i = exc;
        #1;
        chk("T_core_ready", core_req_ready_o, port == 1'b0);
        chk("T_dbg_ready", dbg_req_ready_o, port == 1'b1);
        chk("T_rsp_valid", rsp_valid_o, 0);
        chk("T_csr_cmd", csr_cmd_o, 0);
        @(negedge clk_i);
        core_req_valid_i = 1'b0; dbg_req_valid_i = 1'b0;
        #1;
        chk("T1_csr_cmd", csr_cmd_o, cmd);
        chk("T1_csr_addr", csr_addr_o, addr);
        chk("T1_csr_wdata", csr_wdata_o, wd);
        chk("T1_rsp_valid", rsp_valid_o, 0);
        chk("T1_readies", {core_req_ready_o, dbg_req_ready_o}, 0);
        @(negedge clk_i);
        csr_rdata_i = ~rd; csr_exception_i = ~exc;
        #1;
        chk("T2_rsp_valid", rsp_valid_o, 1);
        chk("T2_rsp_port", rsp_port_o, port);
        chk("T2_rsp_rdata", rsp_rdata_o, rd);
        chk("T2_rsp_err", rsp_err_o, exp_err);
        chk("T2_csr_cmd", csr_cmd_o, 0);
        chk("T2_csr_addr", csr_addr_o, 0);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0; csr_exception_i = 1'b0;
        bump_cnt();
        #1;
        chk("done_rsp_valid", rsp_valid_o, 0);
        chk("done_cnt", access_cnt_o, exp_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_l = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_cnt", access_cnt_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_l = 1'b1;
        exp_cnt = 16'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset_l = 1'b0;
        core_req_valid_i = 0; core_req_addr_i = 0; core_req_cmd_i = 0; core_req_wdata_i = 0;
        dbg_req_valid_i = 0; dbg_req_addr_i = 0; dbg_req_cmd_i = 0; dbg_req_wdata_i = 0;
        rsp_ready_i = 0; csr_rdata_i = 0; csr_exception_i = 0;
        #1;
        chk("reset_readies", {core_req_ready_o, dbg_req_ready_o}, 0);
        chk("reset_rsp", {rsp_valid_o, rsp_port_o, rsp_err_o}, 0);
        chk("reset_rdata", rsp_rdata_o, 0);
        chk("reset_csr", {csr_addr_o, csr_cmd_o, csr_wdata_o}, 0);
        chk("reset_cnt", access_cnt_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_l = 1'b1;

        // Single core read.
        access(1'b0, 12'h300, 3'd5, 64'h0, 64'hA5, 1'b0, 1'b0);

        // Tie after reset: core, debug, core, debug.
        do_reset();
        @(negedge clk_i);
        core_req_valid_i = 1; core_req_addr_i = 12'h100; core_req_cmd_i = 3'd2;
        dbg_req_valid_i = 1; dbg_req_addr_i = 12'h200; dbg_req_cmd_i = 3'd3;
        rsp_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_core_ready", core_req_ready_o, (i % 2) == 0);
            chk("tie_dbg_ready", dbg_req_ready_o, (i % 2) == 1);
            @(negedge clk_i);
            #1;
            chk("tie_csr_addr", csr_addr_o, ((i % 2) == 0) ? 12'h100 : 12'h200);
            @(negedge clk_i);
            #1;
            chk("tie_rsp_valid", rsp_valid_o, 1);
            chk("tie_rsp_port", rsp_port_o, i % 2);
            if (i == 3) begin
                core_req_valid_i = 0; dbg_req_valid_i = 0;
            end
            @(negedge clk_i);
            bump_cnt();
        end
        rsp_ready_i = 0;
        #1;
        chk("tie_cnt", access_cnt_o, 16'd4);

        // Backpressure with both requesters pending.
        @(negedge clk_i);
        core_req_valid_i = 1; core_req_addr_i = 12'h305; core_req_cmd_i = 3'd2;
        dbg_req_valid_i = 1; csr_rdata_i = 64'h1234;
        #1;
        chk("bp_core_ready", core_req_ready_o, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            csr_rdata_i = 64'hF00D_0000 + 64'(i);
            #1;
            chk("bp_rsp_valid", rsp_valid_o, 1);
            chk("bp_rsp_rdata", rsp_rdata_o, 64'h1234);
            chk("bp_readies", {core_req_ready_o, dbg_req_ready_o}, 0);
            chk("bp_csr_cmd", csr_cmd_o, 0);
        end
        core_req_valid_i = 0; dbg_req_valid_i = 0;
        rsp_ready_i = 1;
        @(negedge clk_i);
        rsp_ready_i = 0;
        bump_cnt();
        #1;
        chk("bp_done_valid", rsp_valid_o, 0);
        chk("bp_cnt", access_cnt_o, exp_cnt);

        // Debug write with exception, then a no-op command.
        access(1'b1, 12'h7C0, 3'd1, 64'hDEAD_BEEF, 64'h0, 1'b1, 1'b1);
        access(1'b0, 12'h340, 3'd0, 64'h0, 64'h55, 1'b1, 1'b0);

        // Saturation from a preset counter value.
        @(negedge clk_i);
        force dut.cnt_reg = 16'hFFFE;
        #1;
        release dut.cnt_reg;
        exp_cnt = 16'hFFFE;
        #1;
        chk("sat_preset", access_cnt_o, 16'hFFFE);
        for (int i = 0; i < 3; i++)
            access(1'b0, 12'h301, 3'd5, 64'h0, 64'h77, 1'b0, 1'b0);
        chk("sat_final", access_cnt_o, 16'hFFFF);

        // Reset while in RESP aborts the access.
        @(negedge clk_i);
        core_req_valid_i = 1; core_req_addr_i = 12'h302; core_req_cmd_i = 3'd5;
        csr_rdata_i = 64'h99;
        @(negedge clk_i);
        core_req_valid_i = 0;
        @(negedge clk_i);
        #1;
        chk("rr_in_resp", rsp_valid_o, 1);
        core_req_valid_i = 1;
        #2;
        reset_l = 0;
        #1;
        chk("rr_rsp", {rsp_valid_o, rsp_port_o, rsp_err_o}, 0);
        chk("rr_rdata", rsp_rdata_o, 0);
        chk("rr_readies", {core_req_ready_o, dbg_req_ready_o}, 0);
        chk("rr_csr", {csr_addr_o, csr_cmd_o, csr_wdata_o}, 0);
        chk("rr_cnt", access_cnt_o, 0);
        @(negedge clk_i);
        core_req_valid_i = 0;
        @(negedge clk_i);
        reset_l = 1;
        exp_cnt = 16'd0;
        access(1'b0, 12'h300, 3'd5, 64'h0, 64'hA5, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
